// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM encodings,
// 100 MHz timing defaults and the board-wide key indices.
package key_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED   = 2'b00,
    KEY_PRESS_DB   = 2'b01,
    KEY_PRESSED    = 2'b10,
    KEY_RELEASE_DB = 2'b11
  } key_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 2000000;    // 20 ms at 100 MHz
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 100000000;  // 1 s at 100 MHz

  localparam int unsigned KEY_COUNT = 5;
  localparam int unsigned KEY_LEFT  = 0;
  localparam int unsigned KEY_RIGHT = 1;
  localparam int unsigned KEY_UP    = 2;
  localparam int unsigned KEY_DOWN  = 3;
  localparam int unsigned KEY_MID   = 4;

endpackage

// File: rtl/key_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold counter and
// registered level / press / release / long-press outputs.
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DebW-1:0]  DebMax   = DebW'(DEBOUNCE_CYCLES);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);

  logic             sync1_q, sync2_q;
  key_state_e       state_q, state_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= KEY_RELEASED;
      deb_q   <= '0;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      KEY_RELEASED: begin
        if (sync2_q) begin
          state_d = KEY_PRESS_DB;
          deb_d   = DebW'(1);
        end
      end
      KEY_PRESS_DB: begin
        if (!sync2_q) begin
          state_d = KEY_RELEASED;
          deb_d   = '0;
        end else if (deb_q == DebMax) begin
          state_d = KEY_PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + DebW'(1);
        end
      end
      KEY_PRESSED: begin
        if (!sync2_q) begin
          state_d = KEY_RELEASE_DB;
          deb_d   = DebW'(1);
        end else if (hold_q < HoldMax) begin
          // Saturating at HoldMax makes the long-press pulse fire once per hold.
          hold_d = hold_q + HoldW'(1);
          long_d = (hold_q == HoldLast);
        end
      end
      KEY_RELEASE_DB: begin
        // Returning to PRESSED keeps hold_q so a release bounce cannot re-arm long-press.
        if (sync2_q) begin
          state_d = KEY_PRESSED;
        end else if (deb_q == DebMax) begin
          state_d = KEY_RELEASED;
          rel_d   = 1'b1;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + DebW'(1);
        end
      end
      default: begin
        state_d = KEY_RELEASED;
        deb_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    key_level        = (state_q == KEY_PRESSED) || (state_q == KEY_RELEASE_DB);
    press_pulse      = press_q;
    release_pulse    = rel_q;
    long_press_pulse = long_q;
  end

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: N_KEYS independent debounce channels
// whose per-key outputs are gathered into bus-wide vectors.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS            = KEY_COUNT,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_press_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_chan (
      .clk             (clk),
      .reset           (reset),
      .key_raw         (key_raw[i]),
      .key_level       (key_level[i]),
      .press_pulse     (press_pulse[i]),
      .release_pulse   (release_pulse[i]),
      .long_press_pulse(long_press_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10;
// expected pulses are hand-derived edge numbers counted from the first raw sample.
module tb_key_conditioner;

  localparam int unsigned NK = 5;
  localparam int unsigned DB = 4;
  localparam int unsigned LP = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] long_press_pulse;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS           (NK),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .key_raw         (key_raw),
    .key_level       (key_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int k, input logic [NK-1:0] lvl,
                           input logic [NK-1:0] pr, input logic [NK-1:0] rl,
                           input logic [NK-1:0] lg);
    check_eq($sformatf("%s level k=%0d", tag, k), 32'(key_level), 32'(lvl));
    check_eq($sformatf("%s press k=%0d", tag, k), 32'(press_pulse), 32'(pr));
    check_eq($sformatf("%s release k=%0d", tag, k), 32'(release_pulse), 32'(rl));
    check_eq($sformatf("%s long k=%0d", tag, k), 32'(long_press_pulse), 32'(lg));
  endtask

  // Advance one active edge and land on the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [NK-1:0] bit_if(input bit c, input int idx);
    logic [NK-1:0] v;
    v      = '0;
    v[idx] = c;
    return v;
  endfunction

  initial begin
    logic [NK-1:0] m;
    reset   = 1'b0;
    key_raw = '0;
    @(negedge clk);
    @(negedge clk);
    check_all("reset", 0, '0, '0, '0, '0);
    reset = 1'b1;
    step();
    step();

    // Clean press of key 0: raw high edges 0..7, low from edge 8.
    key_raw[0] = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step();
      check_all("s1", k, bit_if(k >= 6 && k < 14, 0), bit_if(k == 6, 0),
                bit_if(k == 14, 0), '0);
      if (k == 7) key_raw[0] = 1'b0;
    end

    // Glitch on key 1: high for edges 0..2 only.
    key_raw[1] = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step();
      check_all("s2", k, '0, '0, '0, '0);
      if (k == 2) key_raw[1] = 1'b0;
    end

    // Long hold of key 2: raw high edges 0..29.
    key_raw[2] = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      check_all("s3", k, bit_if(k >= 6 && k < 36, 2), bit_if(k == 6, 2),
                bit_if(k == 36, 2), bit_if(k == 16, 2));
      if (k == 29) key_raw[2] = 1'b0;
    end

    // Release bounce on key 0: low at 10,11, high at 12,13, low from 14.
    key_raw[0] = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      step();
      check_all("s4", k, bit_if(k >= 6 && k < 20, 0), bit_if(k == 6, 0),
                bit_if(k == 20, 0), '0);
      if (k == 9)  key_raw[0] = 1'b0;
      if (k == 11) key_raw[0] = 1'b1;
      if (k == 13) key_raw[0] = 1'b0;
    end

    // Keys 0 and 4 pressed on the same edge.
    m       = 5'b10001;
    key_raw = m;
    for (int k = 0; k <= 16; k++) begin
      step();
      check_all("s5", k, (k >= 6 && k < 14) ? m : '0, (k == 6) ? m : '0,
                (k == 14) ? m : '0, '0);
      if (k == 7) key_raw = '0;
    end

    // Reset mid-hold on key 3 with the key still held through deassertion.
    key_raw[3] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      check_all("s6pre", k, bit_if(k >= 6, 3), bit_if(k == 6, 3), '0, '0);
    end
    reset = 1'b0;
    #1;
    check_all("s6rst", 0, '0, '0, '0, '0);
    for (int j = 1; j <= 2; j++) begin
      step();
      check_all("s6rst", j, '0, '0, '0, '0);
    end
    reset = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      step();
      check_all("s6post", k, bit_if(k >= 6, 3), bit_if(k == 6, 3), '0, bit_if(k == 16, 3));
    end
    key_raw = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
